// File: rtl/reg_pair_pipe_pkg.sv
// Shared types for the two-stage register-pair pipeline: sequencer states and default widths.
// No logic here; imported by the stage and the top.
package reg_pair_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/reg_pair_stage.sv
// Valid-qualified operand pair register: load captures data and valid, clr_vld drops valid only.
// Zero latency beyond the register; holds everything when neither load nor clr_vld is asserted.
module reg_pair_stage
   import reg_pair_pipe_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clr_vld_i,
   input  logic         vld_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         vld_o,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o
);

   logic         vld_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (load_i) begin
         vld_q <= vld_i;
         a_q   <= a_i;
         b_q   <= b_i;
      end else if (clr_vld_i) begin
         vld_q <= 1'b0;
      end
   end

   assign vld_o = vld_q;
   assign a_o   = a_q;
   assign b_o   = b_q;

endmodule

// File: rtl/reg_pair_pipe_ctrl.sv
// Handshaked two-stage operand-pair pipeline feeding a wrap-around adder; accept-to-output latency 2 cycles.
// out_rd low stalls stage 1, then stage 0, then in_rd; flush drains the pipe and pulses flush_done.
module reg_pair_pipe_ctrl
   import reg_pair_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              flush,
   input  logic              in_vld,
   output logic              in_rd,
   input  logic [DATA_W-1:0] i0,
   input  logic [DATA_W-1:0] i1,
   output logic              out_vld,
   input  logic              out_rd,
   output logic [DATA_W-1:0] o,
   output logic [1:0]        occupancy,
   output logic              flush_done,
   output logic              busy,
   output logic [CNT_W-1:0]  done_cnt,
   input  logic              clr_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t            state_q;
   logic              flush_done_q;
   logic [CNT_W-1:0]  done_cnt_q;
   logic [CNT_W-1:0]  done_cnt_d;

   logic              v0, v1;
   logic [DATA_W-1:0] r0_0, r0_1, r1_0, r1_1;
   logic              adv0, adv1, accept;

   // in_rd depends only on stage state, out_rd and the FSM, never on in_vld
   assign adv1   = !v1 | out_rd;
   assign adv0   = !v0 | adv1;
   assign in_rd  = adv0 & (state_q == RUN);
   assign accept = in_vld & in_rd;

   reg_pair_stage #(.W(DATA_W)) u_stage0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .clr_vld_i (adv1),
      .vld_i     (1'b1),
      .a_i       (i0),
      .b_i       (i1),
      .vld_o     (v0),
      .a_o       (r0_0),
      .b_o       (r0_1)
   );

   reg_pair_stage #(.W(DATA_W)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (adv1),
      .clr_vld_i (1'b0),
      .vld_i     (v0),
      .a_i       (r0_0),
      .b_i       (r0_1),
      .vld_o     (v1),
      .a_o       (r1_0),
      .b_o       (r1_1)
   );

   assign o         = r1_0 + r1_1;
   assign out_vld   = v1;
   assign occupancy = {1'b0, v0} + {1'b0, v1};
   assign busy      = (state_q != IDLE) | v0 | v1;

   // flush_done is high exactly while the FSM sits in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush)   state_q <= DRAIN;
               else if (en) state_q <= RUN;
            end
            RUN: begin
               if (flush)    state_q <= DRAIN;
               else if (!en) state_q <= IDLE;
            end
            DRAIN: begin
               if (!v0 && !v1) begin
                  state_q      <= DONE;
                  flush_done_q <= 1'b1;
               end
            end
            DONE:    state_q <= en ? RUN : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      done_cnt_d = done_cnt_q;
      if (clr_cnt)            done_cnt_d = '0;
      else if (v1 && out_rd)  done_cnt_d = done_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_cnt_q <= '0;
      else        done_cnt_q <= done_cnt_d;
   end

   assign flush_done = flush_done_q;
   assign done_cnt   = done_cnt_q;

endmodule
